// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
// Contents: default widths, FSM state encoding, requester index constants.
package regfile_pkg;

    localparam int DEF_REG_SELECT_WIDTH = 5;
    localparam int DEF_DATA_WIDTH       = 32;

    // Top-level arbiter states: normal arbitration or zero-fill sweep.
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Requester identifiers, also used as the encoding of the Last pointer.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant.
// Ports:
//   a_valid, b_valid : requests from A and B
//   last             : requester granted most recently (REQ_A / REQ_B)
//   enable           : grants may be issued this cycle
//   grant_a, grant_b : one-hot (or zero) grant
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last,
    input  logic enable,
    output logic grant_a,
    output logic grant_b
);

    // Grant selection: a tie goes to whichever requester was not served last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (enable) begin
            if (a_valid && b_valid) begin
                if (last == REQ_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end else begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between requester A (ALU
// writeback) and requester B (memory load) with round-robin fairness, and
// runs a zero-fill sweep over every register on ClearStart.
// Ports:
//   Clk, Reset                   clock, asynchronous active-high reset
//   AValid/ASelect/AData/AReady  requester A handshake (AReady combinational)
//   BValid/BSelect/BData/BReady  requester B handshake (BReady combinational)
//   ClearStart                   pulse that starts the zero-fill sweep
//   Busy, ClearDone              sweep status (registered)
//   WriteEnable/Select/Data      registered drive to the register file
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int REG_SELECT_WIDTH = DEF_REG_SELECT_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        AValid,
    input  logic [REG_SELECT_WIDTH-1:0] ASelect,
    input  logic [DATA_WIDTH-1:0]       AData,
    output logic                        AReady,
    input  logic                        BValid,
    input  logic [REG_SELECT_WIDTH-1:0] BSelect,
    input  logic [DATA_WIDTH-1:0]       BData,
    output logic                        BReady,
    input  logic                        ClearStart,
    output logic                        Busy,
    output logic                        ClearDone,
    output logic                        WriteEnable,
    output logic [REG_SELECT_WIDTH-1:0] WriteSelect,
    output logic [DATA_WIDTH-1:0]       WriteData
);

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic                        last_r;
    logic                        last_nxt_s;
    logic [REG_SELECT_WIDTH-1:0] clear_idx_r;
    logic [REG_SELECT_WIDTH-1:0] clear_idx_nxt_s;
    logic                        we_r;
    logic                        we_nxt_s;
    logic [REG_SELECT_WIDTH-1:0] sel_r;
    logic [REG_SELECT_WIDTH-1:0] sel_nxt_s;
    logic [DATA_WIDTH-1:0]       data_r;
    logic [DATA_WIDTH-1:0]       data_nxt_s;
    logic                        busy_r;
    logic                        busy_nxt_s;
    logic                        done_r;
    logic                        done_nxt_s;
    logic                        arb_enable_s;
    logic                        grant_a_s;
    logic                        grant_b_s;
    logic                        clear_last_s;

    // ClearStart outranks both requesters, so arbitration is blocked in that cycle.
    assign arb_enable_s = (state_r == ST_ARB) && !ClearStart;
    assign clear_last_s = (clear_idx_r == {REG_SELECT_WIDTH{1'b1}});

    rr_arbiter2 u_rr (
        .a_valid (AValid),
        .b_valid (BValid),
        .last    (last_r),
        .enable  (arb_enable_s),
        .grant_a (grant_a_s),
        .grant_b (grant_b_s)
    );

    assign AReady      = grant_a_s;
    assign BReady      = grant_b_s;
    assign Busy        = busy_r;
    assign ClearDone   = done_r;
    assign WriteEnable = we_r;
    assign WriteSelect = sel_r;
    assign WriteData   = data_r;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: enter the sweep on ClearStart, leave after the last index.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARB: begin
                if (ClearStart) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_CLEAR: begin
                if (clear_last_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: state_nxt_s = ST_ARB;
        endcase
    end

    // Output logic: next values of the write port, sweep status, Last pointer and index.
    always_comb begin
        we_nxt_s        = 1'b0;
        sel_nxt_s       = sel_r;
        data_nxt_s      = data_r;
        last_nxt_s      = last_r;
        clear_idx_nxt_s = clear_idx_r;
        done_nxt_s      = 1'b0;
        busy_nxt_s      = (state_nxt_s == ST_CLEAR);
        case (state_r)
            ST_ARB: begin
                if (ClearStart) begin
                    clear_idx_nxt_s = {REG_SELECT_WIDTH{1'b0}};
                end else if (grant_a_s) begin
                    we_nxt_s   = 1'b1;
                    sel_nxt_s  = ASelect;
                    data_nxt_s = AData;
                    last_nxt_s = REQ_A;
                end else if (grant_b_s) begin
                    we_nxt_s   = 1'b1;
                    sel_nxt_s  = BSelect;
                    data_nxt_s = BData;
                    last_nxt_s = REQ_B;
                end else begin
                    // No grant: select/data keep their previous values.
                    we_nxt_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                we_nxt_s        = 1'b1;
                sel_nxt_s       = clear_idx_r;
                data_nxt_s      = {DATA_WIDTH{1'b0}};
                // Wraps to zero after the last register, ready for the next sweep.
                clear_idx_nxt_s = clear_idx_r + REG_SELECT_WIDTH'(1'b1);
                done_nxt_s      = clear_last_s;
            end
            default: begin
                we_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered write port, status flags, Last pointer and sweep index.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            we_r        <= 1'b0;
            sel_r       <= {REG_SELECT_WIDTH{1'b0}};
            data_r      <= {DATA_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            last_r      <= REQ_B;
            clear_idx_r <= {REG_SELECT_WIDTH{1'b0}};
        end else begin
            we_r        <= we_nxt_s;
            sel_r       <= sel_nxt_s;
            data_r      <= data_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            last_r      <= last_nxt_s;
            clear_idx_r <= clear_idx_nxt_s;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized phase, all checked against a behavioural reference model and a
// register-file model fed by the write port.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        AValid = 1'b0;
    logic [4:0]  ASelect = 5'd0;
    logic [31:0] AData = 32'd0;
    logic        AReady;
    logic        BValid = 1'b0;
    logic [4:0]  BSelect = 5'd0;
    logic [31:0] BData = 32'd0;
    logic        BReady;
    logic        ClearStart = 1'b0;
    logic        Busy;
    logic        ClearDone;
    logic        WriteEnable;
    logic [4:0]  WriteSelect;
    logic [31:0] WriteData;

    regfile_write_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .AValid      (AValid),
        .ASelect     (ASelect),
        .AData       (AData),
        .AReady      (AReady),
        .BValid      (BValid),
        .BSelect     (BSelect),
        .BData       (BData),
        .BReady      (BReady),
        .ClearStart  (ClearStart),
        .Busy        (Busy),
        .ClearDone   (ClearDone),
        .WriteEnable (WriteEnable),
        .WriteSelect (WriteSelect),
        .WriteData   (WriteData)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Register file fed by the DUT, and the register contents the rules predict.
    logic [31:0] rf_obs [32];
    logic [31:0] rf_exp [32];

    always @(posedge Clk) begin
        if (WriteEnable === 1'b1) rf_obs[WriteSelect] <= WriteData;
    end

    // Requester state driven by the bench.
    bit          a_pend = 0;
    logic [4:0]  a_sel = 5'd0;
    logic [31:0] a_data = 32'd0;
    bit          b_pend = 0;
    logic [4:0]  b_sel = 5'd0;
    logic [31:0] b_data = 32'd0;

    // Reference model state.
    bit          m_clearing;
    int          m_idx;
    int          m_last;      // 0 = A served last, 1 = B served last
    logic        m_we;
    logic [4:0]  m_sel;
    logic [31:0] m_data;
    logic        m_busy;
    logic        m_done;

    int busy_cnt = 0;
    int done_cnt = 0;
    int we_cnt   = 0;
    logic dut_aready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clearing = 0; m_idx = 0; m_last = 1;
        m_we = 1'b0; m_sel = 5'd0; m_data = 32'd0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic drive_inputs();
        AValid = a_pend; ASelect = a_sel; AData = a_data;
        BValid = b_pend; BSelect = b_sel; BData = b_data;
    endtask

    // One clock cycle: predict, check readies, clock, check registered outputs.
    task automatic cycle(input logic cs);
        bit ga, gb, n_done;
        drive_inputs();
        ClearStart = cs;
        #1;
        ga = 0; gb = 0; n_done = 0;
        if (m_clearing) begin
            m_we = 1'b1; m_sel = 5'(m_idx); m_data = 32'd0;
            rf_exp[m_idx] = 32'd0;
            if (m_idx == 31) begin
                m_clearing = 0; m_idx = 0; n_done = 1;
            end else begin
                m_idx++;
            end
        end else if (cs) begin
            m_clearing = 1; m_idx = 0; m_we = 1'b0;
        end else begin
            if (a_pend && b_pend) begin
                if (m_last == 1) ga = 1; else gb = 1;
            end else begin
                ga = a_pend; gb = b_pend;
            end
            if (ga) begin
                m_we = 1'b1; m_sel = a_sel; m_data = a_data; m_last = 0; rf_exp[a_sel] = a_data;
            end else if (gb) begin
                m_we = 1'b1; m_sel = b_sel; m_data = b_data; m_last = 1; rf_exp[b_sel] = b_data;
            end else begin
                m_we = 1'b0;
            end
        end
        m_done = n_done;
        m_busy = m_clearing;
        dut_aready = AReady;
        chk("a_ready", {31'd0, AReady}, {31'd0, ga});
        chk("b_ready", {31'd0, BReady}, {31'd0, gb});
        @(posedge Clk);
        #1;
        ClearStart = 1'b0;
        if (ga) a_pend = 0;
        if (gb) b_pend = 0;
        drive_inputs();
        chk("write_enable", {31'd0, WriteEnable}, {31'd0, m_we});
        chk("write_select", {27'd0, WriteSelect}, {27'd0, m_sel});
        chk("write_data", WriteData, m_data);
        chk("busy", {31'd0, Busy}, {31'd0, m_busy});
        chk("clear_done", {31'd0, ClearDone}, {31'd0, m_done});
        if (Busy === 1'b1) busy_cnt++;
        if (ClearDone === 1'b1) done_cnt++;
        if (WriteEnable === 1'b1) we_cnt++;
    endtask

    task automatic req_a(input logic [4:0] s, input logic [31:0] d);
        a_pend = 1; a_sel = s; a_data = d;
    endtask

    task automatic req_b(input logic [4:0] s, input logic [31:0] d);
        b_pend = 1; b_sel = s; b_data = d;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((a_pend || b_pend || m_clearing) && n < budget) begin
            cycle(1'b0);
            n++;
        end
        chk(tag, {30'd0, a_pend, b_pend}, 32'd0);
        cycle(1'b0);
        cycle(1'b0);
    endtask

    task automatic compare_rf(input string tag);
        for (int r = 0; r < 32; r++) chk(tag, rf_obs[r], rf_exp[r]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ai, bi, first;
        for (int r = 0; r < 32; r++) rf_exp[r] = 32'd0;
        model_reset();

        // Reset state.
        #1;
        chk("rst_we", {31'd0, WriteEnable}, 32'd0);
        chk("rst_sel", {27'd0, WriteSelect}, 32'd0);
        chk("rst_data", WriteData, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, ClearDone}, 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
        cycle(1'b0);

        // Single A write.
        req_a(5'd3, 32'hDEADBEEF);
        cycle(1'b0);
        chk("single_a_sel", {27'd0, WriteSelect}, 32'd3);
        drain("single_a_drain", 4);
        chk("single_a_reg3", rf_obs[3], 32'hDEADBEEF);

        // Contention: 4 writes each, back-to-back.
        ai = 0; bi = 0; n = 0; we_cnt = 0;
        while ((ai < 4 || bi < 4 || a_pend || b_pend) && n < 40) begin
            if (!a_pend && ai < 4) begin req_a(5'(1 + ai), $urandom); ai++; end
            if (!b_pend && bi < 4) begin req_b(5'(5 + bi), $urandom); bi++; end
            cycle(1'b0);
            n++;
        end
        chk("contention_cycles", n, 32'd8);
        chk("contention_writes", we_cnt, 32'd8);
        drain("contention_drain", 4);

        // Same register from both after a B grant: A first, B's value survives.
        req_b(5'd9, 32'h99);
        drain("same_reg_pre", 4);
        req_a(5'd2, 32'h1);
        req_b(5'd2, 32'h2);
        drain("same_reg_drain", 6);
        chk("same_reg_final", rf_obs[2], 32'h2);

        // Preload every register with nonzero data.
        for (int r = 0; r < 32; r++) begin
            if (r % 2 == 0) req_a(5'(r), $urandom | 32'h1);
            else            req_b(5'(r), $urandom | 32'h1);
            drain("preload", 4);
        end
        compare_rf("preload_rf");

        // Clear sweep with A held throughout and ClearStart re-pulsed mid-sweep.
        req_a(5'd10, 32'hA5A5A5A5);
        busy_cnt = 0; done_cnt = 0; first = -1;
        cycle(1'b1);
        for (int i = 0; i < 34; i++) begin
            cycle((i == 5 || i == 20) ? 1'b1 : 1'b0);
            if (dut_aready === 1'b1 && first < 0) first = i;
        end
        chk("sweep_busy_cycles", busy_cnt, 32'd32);
        chk("sweep_done_pulses", done_cnt, 32'd1);
        chk("sweep_first_grant", first, 32'd32);
        drain("sweep_drain", 4);
        compare_rf("sweep_rf");

        // Randomized traffic with occasional sweeps.
        for (int i = 0; i < 400; i++) begin
            if (!a_pend && $urandom_range(1, 0) == 1) req_a(5'($urandom), $urandom);
            if (!b_pend && $urandom_range(1, 0) == 1) req_b(5'($urandom), $urandom);
            cycle(($urandom_range(99, 0) == 0) ? 1'b1 : 1'b0);
        end
        drain("random_drain", 80);
        compare_rf("random_rf");

        // Reset in the middle of a sweep at index 7.
        cycle(1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0);
        chk("mid_sweep_busy", {31'd0, Busy}, 32'd1);
        done_cnt = 0;
        Reset = 1'b1;
        #1;
        chk("mid_rst_we", {31'd0, WriteEnable}, 32'd0);
        chk("mid_rst_sel", {27'd0, WriteSelect}, 32'd0);
        chk("mid_rst_data", WriteData, 32'd0);
        chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
        chk("mid_rst_done", {31'd0, ClearDone}, 32'd0);
        model_reset();
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0);
        chk("mid_rst_no_done", done_cnt, 32'd0);
        req_a(5'd4, 32'h12345678);
        req_b(5'd5, 32'h87654321);
        cycle(1'b0);
        chk("post_rst_a_first", {31'd0, dut_aready}, 32'd1);
        drain("post_rst_drain", 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
